// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned N x N shift-add multiplier.
// One AdderNbit accumulates a gated partial product per clock; after N
// steps the 2N-bit accumulator holds A*B and is copied into product.

// Plain N-bit adder with carry in/out; used as the partial-product accumulator.
module AdderNbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign sum   = total[N-1:0];
    assign cout  = total[N];

endmodule

module seq_shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    mcand;
    logic [CW-1:0]   cnt;

    logic [N-1:0]    addend;
    logic [N-1:0]    sum;
    logic            cout;
    logic [2*N-1:0]  next_acc;

    // Multiplicand is added only when the current low multiplier bit is set.
    assign addend = mcand & {N{acc[0]}};

    AdderNbit #(
        .N(N)
    ) u_adder (
        .a    (acc[2*N-1:N]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Add result (with carry) becomes the new high half while the low half
    // shifts right, retiring one multiplier bit per step.
    assign next_acc = {cout, sum, acc[N-1:1]};

    // Control FSM and datapath registers; busy/done are registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        mcand <= multiplicand;
                        acc   <= {{N{1'b0}}, multiplier};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end

                CALC: begin
                    acc <= next_acc;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        product <= next_acc;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= multiplicand;
                        acc   <= {{N{1'b0}}, multiplier};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: an N=8 and an N=4 build
// checked against plain a*b arithmetic and the N-clock latency rule.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  mcand8 = '0;
    logic [7:0]  mplier8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    logic        start4 = 1'b0;
    logic [3:0]  mcand4 = '0;
    logic [3:0]  mplier4 = '0;
    logic        busy4;
    logic        done4;
    logic [7:0]  prod4;

    int checks = 0;
    int fails  = 0;

    seq_shift_add_multiplier #(.N(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .multiplicand (mcand8),
        .multiplier   (mplier8),
        .busy         (busy8),
        .done         (done8),
        .product      (prod8)
    );

    seq_shift_add_multiplier #(.N(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start4),
        .multiplicand (mcand4),
        .multiplier   (mplier4),
        .busy         (busy4),
        .done         (done4),
        .product      (prod4)
    );

    always #5 clk = ~clk;

    // advance past the next rising edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    function automatic logic [15:0] get_prod(input int w);
        return (w == 4) ? {8'h00, prod4} : prod8;
    endfunction

    task automatic drive(input int w, input int unsigned a, input int unsigned b, input logic s);
        if (w == 4) begin
            mcand4  = 4'(a);
            mplier4 = 4'(b);
            start4  = s;
        end else begin
            mcand8  = 8'(a);
            mplier8 = 8'(b);
            start8  = s;
        end
    endtask

    // one start pulse; reports latency (edges after acceptance), product at done,
    // busy cycles seen before done and busy level in the done cycle
    task automatic do_op(input int w, input int unsigned a, input int unsigned b,
                         output int lat, output logic [15:0] prod,
                         output int busy_cycles, output logic busy_at_done);
        int n;
        n = (w == 4) ? 4 : 8;
        lat = -1;
        prod = '0;
        busy_cycles = 0;
        busy_at_done = 1'b0;
        drive(w, a, b, 1'b1);
        tick();
        drive(w, $urandom, $urandom, 1'b0);
        if (get_busy(w)) busy_cycles++;
        for (int k = 1; k <= 4 * n; k++) begin
            tick();
            if (get_done(w)) begin
                lat = k;
                prod = get_prod(w);
                busy_at_done = get_busy(w);
                break;
            end
            if (get_busy(w)) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_n8: busy=%b done=%b product=%h expected 0 0 0000", busy8, done8, prod8);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
            fails++;
            $display("FAIL reset_n4: busy=%b done=%b product=%h expected 0 0 00", busy4, done4, prod4);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b done=%b product=%h expected 0 0 0000", busy8, done8, prod8);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [15:0] p;
        logic bd;
        do_op(8, 13, 11, lat, p, bc, bd);
        checks++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 8", lat);
        end
        checks++;
        if (p !== 16'h008F) begin
            fails++;
            $display("FAIL basic_product: got %h expected 008f", p);
        end
        checks++;
        if (bc !== 8) begin
            fails++;
            $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
        end
        checks++;
        if (bd !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_at_done: got %b expected 0", bd);
        end
        tick();
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse_width: done=%b busy=%b expected 0 0", done8, busy8);
        end
        repeat (3) tick();
        checks++;
        if (prod8 !== 16'h008F) begin
            fails++;
            $display("FAIL basic_product_hold: got %h expected 008f", prod8);
        end
    endtask

    task automatic test_max_carry();
        int lat, bc;
        logic [15:0] p;
        logic bd;
        do_op(8, 255, 255, lat, p, bc, bd);
        checks++;
        if (p !== 16'hFE01 || lat !== 8) begin
            fails++;
            $display("FAIL max_carry: product=%h latency=%0d expected fe01 8", p, lat);
        end
        tick();
    endtask

    task automatic test_zero();
        int lat, bc;
        logic [15:0] p;
        logic bd;
        do_op(8, 0, 200, lat, p, bc, bd);
        checks++;
        if (p !== 16'h0000 || lat !== 8) begin
            fails++;
            $display("FAIL zero_mcand: product=%h latency=%0d expected 0000 8", p, lat);
        end
        tick();
        do_op(8, 200, 0, lat, p, bc, bd);
        checks++;
        if (p !== 16'h0000 || lat !== 8) begin
            fails++;
            $display("FAIL zero_mplier: product=%h latency=%0d expected 0000 8", p, lat);
        end
        tick();
    endtask

    task automatic test_random();
        int lat, bc;
        logic [15:0] p;
        logic bd;
        int unsigned a, b, expv;
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(255);
            b = $urandom_range(255);
            expv = a * b;
            do_op(8, a, b, lat, p, bc, bd);
            checks++;
            if (p !== expv[15:0] || lat !== 8 || bc !== 8) begin
                fails++;
                $display("FAIL random_%0d: %0d*%0d product=%0d latency=%0d busy=%0d expected %0d 8 8",
                         i, a, b, p, lat, bc, expv);
            end
            if ($urandom_range(1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int ndone, first_k;
        logic [15:0] p;
        ndone = 0;
        first_k = -1;
        p = '0;
        drive(8, 7, 9, 1'b1);
        tick();
        drive(8, 0, 0, 1'b0);
        repeat (3) tick();
        drive(8, 100, 100, 1'b1);
        tick();
        drive(8, 100, 100, 1'b0);
        for (int k = 5; k <= 24; k++) begin
            tick();
            if (done8) begin
                ndone++;
                if (first_k < 0) begin
                    first_k = k;
                    p = prod8;
                end
            end
        end
        checks++;
        if (ndone !== 1) begin
            fails++;
            $display("FAIL busy_start_done_count: got %0d expected 1", ndone);
        end
        checks++;
        if (first_k !== 8 || p !== 16'd63) begin
            fails++;
            $display("FAIL busy_start_result: cycle=%0d product=%0d expected 8 63", first_k, p);
        end
        checks++;
        if (prod8 !== 16'd63) begin
            fails++;
            $display("FAIL busy_start_hold: got %0d expected 63", prod8);
        end
    endtask

    task automatic test_back_to_back();
        int k1, k2;
        logic [15:0] p1, p2;
        int held_bad;
        k1 = -1;
        k2 = -1;
        p1 = '0;
        p2 = '0;
        held_bad = 0;
        drive(8, 3, 5, 1'b1);
        tick();
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (done8) begin
                k1 = k;
                p1 = prod8;
                break;
            end
        end
        drive(8, 6, 7, 1'b1);
        for (int j = 1; j <= 24; j++) begin
            tick();
            if (done8) begin
                k2 = j;
                p2 = prod8;
                drive(8, 0, 0, 1'b0);
                break;
            end
            if (prod8 !== 16'd15) held_bad++;
        end
        drive(8, 0, 0, 1'b0);
        checks++;
        if (k1 !== 8 || p1 !== 16'd15) begin
            fails++;
            $display("FAIL b2b_first: cycle=%0d product=%0d expected 8 15", k1, p1);
        end
        checks++;
        if (k2 !== 9 || p2 !== 16'd42) begin
            fails++;
            $display("FAIL b2b_second: gap=%0d product=%0d expected 9 42", k2, p2);
        end
        checks++;
        if (held_bad !== 0) begin
            fails++;
            $display("FAIL b2b_product_held: %0d cycles differed from 15, expected 0", held_bad);
        end
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_return_idle: busy=%b done=%b expected 0 0", busy8, done8);
        end
    endtask

    task automatic test_n4();
        int lat, bc;
        logic [15:0] p;
        logic bd;
        int unsigned a, b, expv;
        do_op(4, 15, 15, lat, p, bc, bd);
        checks++;
        if (p !== 16'h00E1 || lat !== 4 || bc !== 4) begin
            fails++;
            $display("FAIL n4_max: product=%h latency=%0d busy=%0d expected e1 4 4", p, lat, bc);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(15);
            b = $urandom_range(15);
            expv = a * b;
            do_op(4, a, b, lat, p, bc, bd);
            checks++;
            if (p !== expv[15:0] || lat !== 4) begin
                fails++;
                $display("FAIL n4_random_%0d: %0d*%0d product=%0d latency=%0d expected %0d 4",
                         i, a, b, p, lat, expv);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int ndone, nbusy;
        ndone = 0;
        nbusy = 0;
        drive(8, 200, 150, 1'b1);
        drive(4, 9, 7, 1'b1);
        tick();
        drive(8, 0, 0, 1'b0);
        drive(4, 0, 0, 1'b0);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
            fails++;
            $display("FAIL reset_mid_n8: busy=%b done=%b product=%h expected 0 0 0000", busy8, done8, prod8);
        end
        checks++;
        if (busy4 !== 1'b0 || prod4 !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_n4: busy=%b product=%h expected 0 00", busy4, prod4);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8 || done4) ndone++;
            if (busy8 || busy4) nbusy++;
        end
        checks++;
        if (ndone !== 0 || nbusy !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: done pulses=%0d busy cycles=%0d expected 0 0", ndone, nbusy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_carry();
        test_zero();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_n4();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // hard stop in case a wait ever loops unexpectedly
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
